// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline sequencing bus: hazard-detection inputs from the stage registers,
// stage enable/flush controls, data-memory handshake and status/counters.
`timescale 1ns/1ps

interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // Observed pipeline state
  logic [4:0]       ifid_rs1;
  logic [4:0]       ifid_rs2;
  logic             idex_mem_read;
  logic [4:0]       idex_rd;
  logic             exmem_branch;
  logic             exmem_zero;
  logic             exmem_mem_read;
  logic             exmem_mem_write;
  logic             dmem_ready;

  // Sequencing controls
  logic             dmem_req;
  logic             pc_en;
  logic             pc_sel_branch;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_flush;

  // Status and performance counters
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Datapath side: presents pipeline state, consumes controls
  modport master (
    output ifid_rs1, ifid_rs2, idex_mem_read, idex_rd,
           exmem_branch, exmem_zero, exmem_mem_read, exmem_mem_write, dmem_ready,
    input  dmem_req, pc_en, pc_sel_branch,
           ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           mem_err, stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  ifid_rs1, ifid_rs2, idex_mem_read, idex_rd,
           exmem_branch, exmem_zero, exmem_mem_read, exmem_mem_write, dmem_ready,
    output dmem_req, pc_en, pc_sel_branch,
           ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage pipeline.
// Produces per-stage enable and flush controls for load-use stalls and
// branches resolved in MEM, runs the data-memory req/ready handshake with a
// timeout that halts the pipeline, and keeps saturating stall/flush counters.
// Controls are combinational from state + inputs; state and counters are registered.
`timescale 1ns/1ps

module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5,
  parameter int CNT_W   = 16
) (
  input logic                   clk,
  input logic                   rst,   // synchronous, active-low
  pipeline_hazard_ctrl_if.slave pipe
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [TO_W-1:0]  wait_cnt, wait_nxt;
  logic             mem_err_q, err_set;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             flush_inc;

  logic mem_op, branch_taken, load_use;

  logic dmem_req, pc_en, pc_sel_branch;
  logic ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;

  assign mem_op       = pipe.exmem_mem_read | pipe.exmem_mem_write;
  assign branch_taken = pipe.exmem_branch & pipe.exmem_zero;
  // x0 is hardwired to zero, so a load targeting it never creates a hazard
  assign load_use     = pipe.idex_mem_read && (pipe.idex_rd != 5'd0) &&
                        ((pipe.idex_rd == pipe.ifid_rs1) || (pipe.idex_rd == pipe.ifid_rs2));

  // Control decode and next-state selection; reset forces default controls
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path infers a latch.
    dmem_req      = 1'b0;
    pc_en         = 1'b1;
    pc_sel_branch = 1'b0;
    ifid_en       = 1'b1;
    idex_en       = 1'b1;
    exmem_en      = 1'b1;
    memwb_en      = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    memwb_flush   = 1'b0;
    state_nxt     = state;
    wait_nxt      = wait_cnt;
    err_set       = 1'b0;
    flush_inc     = 1'b0;

    if (rst) begin
      case (state)
        RUN: begin
          if (mem_op) begin
            // A memory op masks any branch in EX/MEM (illegal combination)
            dmem_req = 1'b1;
            if (!pipe.dmem_ready) begin
              pc_en       = 1'b0;
              ifid_en     = 1'b0;
              idex_en     = 1'b0;
              exmem_en    = 1'b0;
              memwb_flush = 1'b1;
              state_nxt   = MEM_WAIT;
              wait_nxt    = TO_W'(1);
            end
          end else if (branch_taken) begin
            pc_sel_branch = 1'b1;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            exmem_flush   = 1'b1;
            flush_inc     = 1'b1;
          end else if (load_use) begin
            // The bubble clears the load from ID/EX, so the stall lasts one cycle
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end

        MEM_WAIT: begin
          dmem_req = 1'b1;
          if (pipe.dmem_ready) begin
            state_nxt = RUN;
            wait_nxt  = '0;
          end else begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
            if (wait_cnt == TO_W'(TIMEOUT)) begin
              err_set   = 1'b1;
              state_nxt = HALT;
            end else begin
              wait_nxt = wait_cnt + 1'b1;
            end
          end
        end

        default: begin
          // HALT: freeze everything until reset
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_en   = 1'b0;
          exmem_en  = 1'b0;
          memwb_en  = 1'b0;
          state_nxt = HALT;
        end
      endcase
    end
  end

  // State, sticky error and saturating performance counters
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    if (!rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (err_set)
        mem_err_q <= 1'b1;
      if (!pc_en && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
      if (flush_inc && (flush_q != '1))
        flush_q <= flush_q + 1'b1;
    end
  end

  assign pipe.dmem_req      = dmem_req;
  assign pipe.pc_en         = pc_en;
  assign pipe.pc_sel_branch = pc_sel_branch;
  assign pipe.ifid_en       = ifid_en;
  assign pipe.idex_en       = idex_en;
  assign pipe.exmem_en      = exmem_en;
  assign pipe.memwb_en      = memwb_en;
  assign pipe.ifid_flush    = ifid_flush;
  assign pipe.idex_flush    = idex_flush;
  assign pipe.exmem_flush   = exmem_flush;
  assign pipe.memwb_flush   = memwb_flush;
  assign pipe.mem_err       = mem_err_q;
  assign pipe.stall_cnt     = stall_q;
  assign pipe.flush_cnt     = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: load-use, branch flush, memory wait,
// timeout/halt, reset recovery and counter saturation (second instance, CNT_W=4).
`timescale 1ns/1ps

module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst;

  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic       idex_mem_read, exmem_branch, exmem_zero;
  logic       exmem_mem_read, exmem_mem_write, dmem_ready;

  int n_cmp = 0;
  int n_mis = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  // Control vector: {dmem_req, pc_en, pc_sel_branch, ifid/idex/exmem/memwb_en, ifid/idex/exmem/memwb_flush}
  localparam logic [10:0] C_DEF   = {1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000};
  localparam logic [10:0] C_LU    = {1'b0, 1'b0, 1'b0, 4'b0111, 4'b0100};
  localparam logic [10:0] C_BR    = {1'b0, 1'b1, 1'b1, 4'b1111, 4'b1110};
  localparam logic [10:0] C_MREQ  = {1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000};
  localparam logic [10:0] C_MWAIT = {1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001};
  localparam logic [10:0] C_HALT  = {1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};

  pipeline_hazard_ctrl_if #(.CNT_W(16)) bus16 ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

  assign bus16.ifid_rs1        = ifid_rs1;
  assign bus16.ifid_rs2        = ifid_rs2;
  assign bus16.idex_mem_read   = idex_mem_read;
  assign bus16.idex_rd         = idex_rd;
  assign bus16.exmem_branch    = exmem_branch;
  assign bus16.exmem_zero      = exmem_zero;
  assign bus16.exmem_mem_read  = exmem_mem_read;
  assign bus16.exmem_mem_write = exmem_mem_write;
  assign bus16.dmem_ready      = dmem_ready;

  assign bus4.ifid_rs1        = ifid_rs1;
  assign bus4.ifid_rs2        = ifid_rs2;
  assign bus4.idex_mem_read   = idex_mem_read;
  assign bus4.idex_rd         = idex_rd;
  assign bus4.exmem_branch    = exmem_branch;
  assign bus4.exmem_zero      = exmem_zero;
  assign bus4.exmem_mem_read  = exmem_mem_read;
  assign bus4.exmem_mem_write = exmem_mem_write;
  assign bus4.dmem_ready      = dmem_ready;

  logic [10:0] ctrl;
  assign ctrl = {bus16.dmem_req, bus16.pc_en, bus16.pc_sel_branch,
                 bus16.ifid_en, bus16.idex_en, bus16.exmem_en, bus16.memwb_en,
                 bus16.ifid_flush, bus16.idex_flush, bus16.exmem_flush, bus16.memwb_flush};

  pipeline_hazard_ctrl #(.TIMEOUT(16), .TO_W(5), .CNT_W(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .pipe (bus16)
  );

  pipeline_hazard_ctrl #(.TIMEOUT(16), .TO_W(5), .CNT_W(4)) dut_sat (
    .clk  (clk),
    .rst  (rst),
    .pipe (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs;
    ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; idex_rd = 5'd0;
    idex_mem_read = 1'b0; exmem_branch = 1'b0; exmem_zero = 1'b0;
    exmem_mem_read = 1'b0; exmem_mem_write = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    clear_inputs();
    idex_mem_read = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd5;
    @(negedge clk); #1;
    n_cmp++; if (ctrl !== C_DEF) begin n_mis++; $display("FAIL reset_forced_default ctrl=%b exp=%b", ctrl, C_DEF); end
    @(negedge clk);
    n_cmp++; if (bus16.stall_cnt !== 16'd0) begin n_mis++; $display("FAIL reset_stall_cnt got=%0d exp=0", bus16.stall_cnt); end
    n_cmp++; if (bus16.flush_cnt !== 16'd0) begin n_mis++; $display("FAIL reset_flush_cnt got=%0d exp=0", bus16.flush_cnt); end
    n_cmp++; if (bus16.mem_err !== 1'b0) begin n_mis++; $display("FAIL reset_mem_err got=%b exp=0", bus16.mem_err); end
    rst = 1'b1;
    clear_inputs();
    exp_stall = 0; exp_flush = 0;
    #1;
    n_cmp++; if (ctrl !== C_DEF) begin n_mis++; $display("FAIL idle_default ctrl=%b exp=%b", ctrl, C_DEF); end
  endtask

  task automatic test_load_use;
    @(negedge clk);
    idex_mem_read = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd5; #1;
    n_cmp++; if (ctrl !== C_LU) begin n_mis++; $display("FAIL lu_rs1 ctrl=%b exp=%b", ctrl, C_LU); end
    @(negedge clk);
    exp_stall++;
    clear_inputs(); #1;
    n_cmp++; if (ctrl !== C_DEF) begin n_mis++; $display("FAIL lu_one_bubble ctrl=%b exp=%b", ctrl, C_DEF); end
    n_cmp++; if (bus16.stall_cnt !== 16'(exp_stall)) begin n_mis++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", bus16.stall_cnt, exp_stall); end
    idex_mem_read = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; #1;
    n_cmp++; if (ctrl !== C_DEF) begin n_mis++; $display("FAIL lu_rd_zero ctrl=%b exp=%b", ctrl, C_DEF); end
    @(negedge clk);
    idex_rd = 5'd7; ifid_rs1 = 5'd3; ifid_rs2 = 5'd7; #1;
    n_cmp++; if (ctrl !== C_LU) begin n_mis++; $display("FAIL lu_rs2 ctrl=%b exp=%b", ctrl, C_LU); end
    @(negedge clk);
    exp_stall++;
    ifid_rs2 = 5'd4; #1;
    n_cmp++; if (ctrl !== C_DEF) begin n_mis++; $display("FAIL lu_no_match ctrl=%b exp=%b", ctrl, C_DEF); end
    @(negedge clk);
    clear_inputs();
    n_cmp++; if (bus16.stall_cnt !== 16'(exp_stall)) begin n_mis++; $display("FAIL lu_stall_cnt2 got=%0d exp=%0d", bus16.stall_cnt, exp_stall); end
  endtask

  task automatic test_branch;
    @(negedge clk);
    clear_inputs();
    exmem_branch = 1'b1; exmem_zero = 1'b1;
    idex_mem_read = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd5; #1;
    n_cmp++; if (ctrl !== C_BR) begin n_mis++; $display("FAIL br_over_lu ctrl=%b exp=%b", ctrl, C_BR); end
    @(negedge clk);
    exp_flush++;
    clear_inputs();
    exmem_branch = 1'b1; exmem_zero = 1'b0; #1;
    n_cmp++; if (ctrl !== C_DEF) begin n_mis++; $display("FAIL br_not_taken ctrl=%b exp=%b", ctrl, C_DEF); end
    n_cmp++; if (bus16.flush_cnt !== 16'(exp_flush)) begin n_mis++; $display("FAIL br_flush_cnt got=%0d exp=%0d", bus16.flush_cnt, exp_flush); end
    n_cmp++; if (bus16.stall_cnt !== 16'(exp_stall)) begin n_mis++; $display("FAIL br_no_stall got=%0d exp=%0d", bus16.stall_cnt, exp_stall); end
    @(negedge clk);
    clear_inputs();
    n_cmp++; if (bus16.flush_cnt !== 16'(exp_flush)) begin n_mis++; $display("FAIL br_flush_hold got=%0d exp=%0d", bus16.flush_cnt, exp_flush); end
  endtask

  task automatic test_mem_wait;
    @(negedge clk);
    clear_inputs();
    exmem_mem_read = 1'b1; dmem_ready = 1'b0; #1;
    n_cmp++; if (ctrl !== C_MWAIT) begin n_mis++; $display("FAIL mw_first ctrl=%b exp=%b", ctrl, C_MWAIT); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (ctrl !== C_MWAIT) begin n_mis++; $display("FAIL mw_hold%0d ctrl=%b exp=%b", i, ctrl, C_MWAIT); end
    end
    @(negedge clk);
    dmem_ready = 1'b1; #1;
    n_cmp++; if (ctrl !== C_MREQ) begin n_mis++; $display("FAIL mw_release ctrl=%b exp=%b", ctrl, C_MREQ); end
    @(negedge clk);
    exp_stall += 3;
    clear_inputs(); #1;
    n_cmp++; if (ctrl !== C_DEF) begin n_mis++; $display("FAIL mw_back_to_run ctrl=%b exp=%b", ctrl, C_DEF); end
    n_cmp++; if (bus16.stall_cnt !== 16'(exp_stall)) begin n_mis++; $display("FAIL mw_stall_cnt got=%0d exp=%0d", bus16.stall_cnt, exp_stall); end
    exmem_mem_read = 1'b1; dmem_ready = 1'b1; #1;
    n_cmp++; if (ctrl !== C_MREQ) begin n_mis++; $display("FAIL mw_zero_wait ctrl=%b exp=%b", ctrl, C_MREQ); end
    @(negedge clk);
    exmem_mem_read = 1'b0; exmem_mem_write = 1'b1;
    exmem_branch = 1'b1; exmem_zero = 1'b1; dmem_ready = 1'b1; #1;
    n_cmp++; if (ctrl !== C_MREQ) begin n_mis++; $display("FAIL mem_beats_branch ctrl=%b exp=%b", ctrl, C_MREQ); end
    @(negedge clk);
    clear_inputs();
    n_cmp++; if (bus16.stall_cnt !== 16'(exp_stall)) begin n_mis++; $display("FAIL mw_zero_wait_stall got=%0d exp=%0d", bus16.stall_cnt, exp_stall); end
    n_cmp++; if (bus16.flush_cnt !== 16'(exp_flush)) begin n_mis++; $display("FAIL mem_branch_no_flush got=%0d exp=%0d", bus16.flush_cnt, exp_flush); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    clear_inputs();
    exmem_mem_read = 1'b1;
    idex_mem_read = 1'b1; idex_rd = 5'd9; ifid_rs2 = 5'd9; #1;
    n_cmp++; if (ctrl !== C_MWAIT) begin n_mis++; $display("FAIL b2b_wait_masks_lu ctrl=%b exp=%b", ctrl, C_MWAIT); end
    @(negedge clk); #1;
    n_cmp++; if (ctrl !== C_MWAIT) begin n_mis++; $display("FAIL b2b_wait2 ctrl=%b exp=%b", ctrl, C_MWAIT); end
    @(negedge clk);
    dmem_ready = 1'b1; #1;
    n_cmp++; if (ctrl !== C_MREQ) begin n_mis++; $display("FAIL b2b_release ctrl=%b exp=%b", ctrl, C_MREQ); end
    @(negedge clk);
    exmem_mem_read = 1'b0; dmem_ready = 1'b0; #1;
    n_cmp++; if (ctrl !== C_LU) begin n_mis++; $display("FAIL b2b_lu_after_release ctrl=%b exp=%b", ctrl, C_LU); end
    @(negedge clk);
    exp_stall += 3;
    clear_inputs();
    exmem_branch = 1'b1; exmem_zero = 1'b1; #1;
    n_cmp++; if (ctrl !== C_BR) begin n_mis++; $display("FAIL b2b_branch ctrl=%b exp=%b", ctrl, C_BR); end
    @(negedge clk);
    exp_flush++;
    clear_inputs();
    n_cmp++; if (bus16.stall_cnt !== 16'(exp_stall)) begin n_mis++; $display("FAIL b2b_stall_cnt got=%0d exp=%0d", bus16.stall_cnt, exp_stall); end
    n_cmp++; if (bus16.flush_cnt !== 16'(exp_flush)) begin n_mis++; $display("FAIL b2b_flush_cnt got=%0d exp=%0d", bus16.flush_cnt, exp_flush); end
  endtask

  task automatic test_timeout;
    @(negedge clk);
    clear_inputs();
    exmem_mem_write = 1'b1; #1;
    n_cmp++; if (ctrl !== C_MWAIT) begin n_mis++; $display("FAIL to_first ctrl=%b exp=%b", ctrl, C_MWAIT); end
    repeat (16) @(negedge clk);
    #1;
    n_cmp++; if (bus16.mem_err !== 1'b0) begin n_mis++; $display("FAIL to_not_yet mem_err=%b exp=0", bus16.mem_err); end
    n_cmp++; if (ctrl !== C_MWAIT) begin n_mis++; $display("FAIL to_still_waiting ctrl=%b exp=%b", ctrl, C_MWAIT); end
    @(negedge clk); #1;
    exp_stall += 17;
    n_cmp++; if (bus16.mem_err !== 1'b1) begin n_mis++; $display("FAIL to_mem_err mem_err=%b exp=1", bus16.mem_err); end
    n_cmp++; if (ctrl !== C_HALT) begin n_mis++; $display("FAIL to_halt ctrl=%b exp=%b", ctrl, C_HALT); end
    n_cmp++; if (bus16.stall_cnt !== 16'(exp_stall)) begin n_mis++; $display("FAIL to_stall_cnt got=%0d exp=%0d", bus16.stall_cnt, exp_stall); end
    exmem_mem_write = 1'b0; dmem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    exp_stall += 3;
    n_cmp++; if (ctrl !== C_HALT) begin n_mis++; $display("FAIL halt_sticky ctrl=%b exp=%b", ctrl, C_HALT); end
    n_cmp++; if (bus16.mem_err !== 1'b1) begin n_mis++; $display("FAIL halt_mem_err mem_err=%b exp=1", bus16.mem_err); end
    n_cmp++; if (bus16.stall_cnt !== 16'(exp_stall)) begin n_mis++; $display("FAIL halt_stall_cnt got=%0d exp=%0d", bus16.stall_cnt, exp_stall); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    rst = 1'b0;
    clear_inputs(); #1;
    n_cmp++; if (ctrl !== C_DEF) begin n_mis++; $display("FAIL rst_from_halt ctrl=%b exp=%b", ctrl, C_DEF); end
    @(negedge clk);
    rst = 1'b1;
    exp_stall = 0; exp_flush = 0;
    n_cmp++; if (bus16.mem_err !== 1'b0) begin n_mis++; $display("FAIL rst_clears_err mem_err=%b exp=0", bus16.mem_err); end
    exmem_mem_write = 1'b1; #1;
    n_cmp++; if (ctrl !== C_MWAIT) begin n_mis++; $display("FAIL rst_wait1 ctrl=%b exp=%b", ctrl, C_MWAIT); end
    @(negedge clk); #1;
    n_cmp++; if (ctrl !== C_MWAIT) begin n_mis++; $display("FAIL rst_wait2 ctrl=%b exp=%b", ctrl, C_MWAIT); end
    rst = 1'b0; #1;
    n_cmp++; if (ctrl !== C_DEF) begin n_mis++; $display("FAIL rst_forced_in_wait ctrl=%b exp=%b", ctrl, C_DEF); end
    @(negedge clk);
    rst = 1'b1;
    clear_inputs(); #1;
    n_cmp++; if (ctrl !== C_DEF) begin n_mis++; $display("FAIL rst_mid_run ctrl=%b exp=%b", ctrl, C_DEF); end
    n_cmp++; if (bus16.stall_cnt !== 16'd0) begin n_mis++; $display("FAIL rst_mid_stall got=%0d exp=0", bus16.stall_cnt); end
    n_cmp++; if (bus16.flush_cnt !== 16'd0) begin n_mis++; $display("FAIL rst_mid_flush got=%0d exp=0", bus16.flush_cnt); end
    n_cmp++; if (bus16.mem_err !== 1'b0) begin n_mis++; $display("FAIL rst_mid_err mem_err=%b exp=0", bus16.mem_err); end
  endtask

  task automatic test_saturation;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      idex_mem_read = 1'b1; idex_rd = 5'd12; ifid_rs1 = 5'd12;
      @(negedge clk);
      clear_inputs();
      exp_stall++;
      if (i == 15) begin
        n_cmp++; if (bus4.stall_cnt !== 4'd15) begin n_mis++; $display("FAIL sat_stall_reach got=%0d exp=15", bus4.stall_cnt); end
      end
    end
    n_cmp++; if (bus4.stall_cnt !== 4'd15) begin n_mis++; $display("FAIL sat_stall_stick got=%0d exp=15", bus4.stall_cnt); end
    n_cmp++; if (bus16.stall_cnt !== 16'(exp_stall)) begin n_mis++; $display("FAIL sat_stall_wide got=%0d exp=%0d", bus16.stall_cnt, exp_stall); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      exmem_branch = 1'b1; exmem_zero = 1'b1;
      @(negedge clk);
      clear_inputs();
      exp_flush++;
    end
    n_cmp++; if (bus4.flush_cnt !== 4'd15) begin n_mis++; $display("FAIL sat_flush_stick got=%0d exp=15", bus4.flush_cnt); end
    n_cmp++; if (bus16.flush_cnt !== 16'(exp_flush)) begin n_mis++; $display("FAIL sat_flush_wide got=%0d exp=%0d", bus16.flush_cnt, exp_flush); end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
